// File: rtl/mem_fill_arbiter_if.sv
// Signal bundle between mem_fill_arbiter, the I/D-cache miss logic and the shared memory port.
// master = arbiter view, slave = cache/memory environment view.
interface mem_fill_arbiter_if;
  logic        icache_miss;
  logic [15:0] icache_addr;
  logic        dcache_miss;
  logic [15:0] dcache_addr;
  logic        wr_req;
  logic [15:0] wr_addr;
  logic        mem_data_valid;
  logic [15:0] mem_addr;
  logic        mem_enable;
  logic        mem_wr;
  logic        fill_we_i;
  logic        fill_we_d;
  logic [2:0]  fill_word_idx;
  logic        fill_done_i;
  logic        fill_done_d;
  logic        wr_ack;
  logic        busy;

  modport master (
    input  icache_miss, icache_addr, dcache_miss, dcache_addr,
    input  wr_req, wr_addr, mem_data_valid,
    output mem_addr, mem_enable, mem_wr,
    output fill_we_i, fill_we_d, fill_word_idx,
    output fill_done_i, fill_done_d, wr_ack, busy
  );

  modport slave (
    output icache_miss, icache_addr, dcache_miss, dcache_addr,
    output wr_req, wr_addr, mem_data_valid,
    input  mem_addr, mem_enable, mem_wr,
    input  fill_we_i, fill_we_d, fill_word_idx,
    input  fill_done_i, fill_done_d, wr_ack, busy
  );
endinterface

// File: rtl/mem_fill_arbiter.sv
// Owner of the shared main-memory port: arbitrates D-write > D-fill > I-fill and sequences 8-word fills.
// Optional macro ROUND_ROBIN_FILL_EN alternates I/D when both misses are pending in IDLE.
module mem_fill_arbiter (
  input  logic               clk,
  input  logic               rst_n,
  mem_fill_arbiter_if.master bus
);

  localparam logic [3:0] WORDS_PER_BLK = 4'd8;
  localparam logic [3:0] LAST_WORD     = 4'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_FILL  = 2'd2
  } state_t;

  state_t      state_q,      state_d;
  logic [3:0]  issue_cnt_q,  issue_cnt_d;
  logic [3:0]  ret_cnt_q,    ret_cnt_d;
  logic [11:0] blk_addr_q,   blk_addr_d;
  logic        dst_is_d_q,   dst_is_d_d;
  logic [15:0] mem_addr_q,   mem_addr_d;
  logic        mem_enable_q, mem_enable_d;
  logic        mem_wr_q,     mem_wr_d;
  logic        wr_ack_q,     wr_ack_d;
  logic        busy_q,       busy_d;
`ifdef ROUND_ROBIN_FILL_EN
  logic        last_fill_q,  last_fill_d;  // 1: most recent fill grant went to D
`endif

  logic        pick_d_s;
  logic [15:0] fill_addr_s;
  logic        ret_take_s;
  logic        ret_last_s;
  logic        unused_s;

  // Choose which pending miss would win a fill grant this cycle.
  always_comb begin
`ifdef ROUND_ROBIN_FILL_EN
    if (bus.dcache_miss && bus.icache_miss) begin
      pick_d_s = ~last_fill_q;
    end else begin
      pick_d_s = bus.dcache_miss;
    end
`else
    pick_d_s = bus.dcache_miss;
`endif
  end

  assign fill_addr_s = pick_d_s ? bus.dcache_addr : bus.icache_addr;
  assign unused_s    = ^fill_addr_s[3:0];

  // Returns only count while a fill is open; strays in IDLE/WRITE fall through.
  assign ret_take_s = (state_q == ST_FILL) && bus.mem_data_valid && (ret_cnt_q < WORDS_PER_BLK);
  assign ret_last_s = ret_take_s && (ret_cnt_q == LAST_WORD);

  // Next-state, counter and registered-output computation.
  always_comb begin
    state_d      = state_q;
    issue_cnt_d  = issue_cnt_q;
    ret_cnt_d    = ret_cnt_q;
    blk_addr_d   = blk_addr_q;
    dst_is_d_d   = dst_is_d_q;
    mem_addr_d   = 16'h0000;
    mem_enable_d = 1'b0;
    mem_wr_d     = 1'b0;
    wr_ack_d     = 1'b0;
`ifdef ROUND_ROBIN_FILL_EN
    last_fill_d  = last_fill_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (bus.wr_req) begin
          state_d      = ST_WRITE;
          mem_enable_d = 1'b1;
          mem_wr_d     = 1'b1;
          mem_addr_d   = bus.wr_addr;
          wr_ack_d     = 1'b1;
        end else if (bus.dcache_miss || bus.icache_miss) begin
          // The grant edge already launches word 0, so the issue burst has no bubble.
          state_d      = ST_FILL;
          blk_addr_d   = fill_addr_s[15:4];
          dst_is_d_d   = pick_d_s;
          mem_enable_d = 1'b1;
          mem_addr_d   = {fill_addr_s[15:4], 4'h0};
          issue_cnt_d  = 4'd1;
          ret_cnt_d    = 4'd0;
`ifdef ROUND_ROBIN_FILL_EN
          last_fill_d  = pick_d_s;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_WRITE: begin
        state_d = ST_IDLE;
      end

      ST_FILL: begin
        if (issue_cnt_q < WORDS_PER_BLK) begin
          mem_enable_d = 1'b1;
          mem_addr_d   = {blk_addr_q, issue_cnt_q[2:0], 1'b0};
          issue_cnt_d  = issue_cnt_q + 4'd1;
        end else begin
          mem_enable_d = 1'b0;
        end

        if (ret_last_s) begin
          state_d      = ST_IDLE;
          issue_cnt_d  = 4'd0;
          ret_cnt_d    = 4'd0;
          mem_enable_d = 1'b0;
          mem_addr_d   = 16'h0000;
        end else if (ret_take_s) begin
          ret_cnt_d = ret_cnt_q + 4'd1;
        end else begin
          ret_cnt_d = ret_cnt_q;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        issue_cnt_d = 4'd0;
        ret_cnt_d   = 4'd0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      issue_cnt_q  <= 4'd0;
      ret_cnt_q    <= 4'd0;
      blk_addr_q   <= 12'h000;
      dst_is_d_q   <= 1'b0;
      mem_addr_q   <= 16'h0000;
      mem_enable_q <= 1'b0;
      mem_wr_q     <= 1'b0;
      wr_ack_q     <= 1'b0;
      busy_q       <= 1'b0;
`ifdef ROUND_ROBIN_FILL_EN
      last_fill_q  <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      issue_cnt_q  <= issue_cnt_d;
      ret_cnt_q    <= ret_cnt_d;
      blk_addr_q   <= blk_addr_d;
      dst_is_d_q   <= dst_is_d_d;
      mem_addr_q   <= mem_addr_d;
      mem_enable_q <= mem_enable_d;
      mem_wr_q     <= mem_wr_d;
      wr_ack_q     <= wr_ack_d;
      busy_q       <= busy_d;
`ifdef ROUND_ROBIN_FILL_EN
      last_fill_q  <= last_fill_d;
`endif
    end
  end

  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_enable = mem_enable_q;
  assign bus.mem_wr     = mem_wr_q;
  assign bus.wr_ack     = wr_ack_q;
  assign bus.busy       = busy_q;

  // Fill strobes qualify the memory word present this cycle, so they follow mem_data_valid directly.
  assign bus.fill_we_i     = ret_take_s && !dst_is_d_q;
  assign bus.fill_we_d     = ret_take_s &&  dst_is_d_q;
  assign bus.fill_word_idx = ret_take_s ? ret_cnt_q[2:0] : 3'd0;
  assign bus.fill_done_i   = ret_last_s && !dst_is_d_q;
  assign bus.fill_done_d   = ret_last_s &&  dst_is_d_q;

endmodule
